pid_sequencer: RTL and testbench

PID_SEQUENCER -- requirements
Module: pid_sequencer

---
 rtl/pid_pkg.sv | 31 +++
 rtl/pid_sample_timer.sv | 34 +++
 rtl/pid_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_pid_sequencer.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/pid_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pid_pkg
// Description : Shared widths, default gains and FSM state encoding for the
//               PID sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package pid_pkg;

    localparam int ERR_W  = 9;          // setpoint - feedback, signed
    localparam int DIFF_W = ERR_W + 1;  // error - prev_error, signed
    localparam int INT_W  = 16;         // integral accumulator, signed
    localparam int SUM_W  = 20;         // P + I + D, signed

    localparam logic [7:0] DEF_KP        = 8'd16;
    localparam logic [7:0] DEF_KI        = 8'd2;
    localparam logic [7:0] DEF_KD        = 8'd1;
    localparam int         DEF_OUT_SHIFT = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_FB = 3'd1,
        MUL_P   = 3'd2,
        MUL_I   = 3'd3,
        MUL_D   = 3'd4,
        SUM     = 3'd5,
        OUT     = 3'd6
    } pid_state_e;

endpackage
`default_nettype wire

// File: rtl/pid_sample_timer.sv
`default_nettype none
// ============================================================================
// Module      : pid_sample_timer
// Description : Down-counting sample timer; ticks at zero and reloads from
//               sample_div. Holds its count while ena is low.
// Revision    : 1.0 - initial release
// ============================================================================
module pid_sample_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] sample_div,
    output logic       tick
);

    logic [7:0] r_count;

    // Count down while enabled, reloading the period on the tick cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 8'd0;
        end else if (ena) begin
            if (r_count == 8'd0) begin
                r_count <= sample_div;
            end else begin
                r_count <= r_count - 8'd1;
            end
        end
    end

    assign tick = ena && (r_count == 8'd0);

endmodule
`default_nettype wire

// File: rtl/pid_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pid_sequencer
// Description : Time-multiplexed PID controller. One shared signed multiplier
//               steps through P, I and D terms per sample, then the sum is
//               scaled, clamped to 0..255 and presented on control.
// Revision    : 1.0 - initial release
// ============================================================================
module pid_sequencer
    import pid_pkg::*;
#(
    parameter logic [7:0] KP        = DEF_KP,
    parameter logic [7:0] KI        = DEF_KI,
    parameter logic [7:0] KD        = DEF_KD,
    parameter int         OUT_SHIFT = DEF_OUT_SHIFT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       clr,
    input  logic [7:0] sample_div,
    input  logic [7:0] setpoint,
    input  logic [7:0] feedback,
    input  logic       fb_valid,
    output logic       sample_req,
    output logic [7:0] control,
    output logic       ctrl_valid,
    output logic       busy,
    output logic       overrun
);

    localparam logic signed [SUM_W-1:0] c_int_max  = SUM_W'(32767);
    localparam logic signed [SUM_W-1:0] c_int_min  = SUM_W'(-32768);
    localparam logic signed [SUM_W-1:0] c_ctrl_max = SUM_W'(255);

    pid_state_e                r_state;
    pid_state_e                w_next_state;
    logic                      w_tick;

    logic signed [ERR_W-1:0]   r_error;
    logic signed [ERR_W-1:0]   r_prev_error;
    logic signed [INT_W-1:0]   r_integral;
    logic signed [SUM_W-1:0]   r_p_term;
    logic signed [SUM_W-1:0]   r_d_term;
    logic [7:0]                r_control;
    logic                      r_overrun;

    logic signed [ERR_W-1:0]   w_err_new;
    logic signed [DIFF_W-1:0]  w_diff;
    logic [7:0]                w_gain;
    logic signed [DIFF_W-1:0]  w_mul_op;
    logic signed [SUM_W-1:0]   w_gain_ext;
    logic signed [SUM_W-1:0]   w_op_ext;
    logic signed [SUM_W-1:0]   w_product;
    logic signed [SUM_W-1:0]   w_int_ext;
    logic signed [SUM_W-1:0]   w_int_sum;
    logic signed [INT_W-1:0]   w_int_sat;
    logic signed [SUM_W-1:0]   w_pid_sum;
    logic signed [SUM_W-1:0]   w_shifted;
    logic [7:0]                w_clamped;

    pid_sample_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .sample_div (sample_div),
        .tick       (w_tick)
    );

    // Operand arithmetic: both sides zero-extended to 9 bits so the
    // difference is always representable as 9-bit signed.
    assign w_err_new = {1'b0, setpoint} - {1'b0, feedback};
    assign w_diff    = {r_error[ERR_W-1], r_error} - {r_prev_error[ERR_W-1], r_prev_error};

    // Select gain and operand for the shared multiplier by FSM phase.
    always_comb begin
        w_gain   = 8'd0;
        w_mul_op = '0;
        case (r_state)
            MUL_P: begin
                w_gain   = KP;
                w_mul_op = {r_error[ERR_W-1], r_error};
            end
            MUL_I: begin
                w_gain   = KI;
                w_mul_op = {r_error[ERR_W-1], r_error};
            end
            MUL_D: begin
                w_gain   = KD;
                w_mul_op = w_diff;
            end
            default: ;
        endcase
    end

    // Gains are unsigned; extend them with zeros, the operand with its sign.
    assign w_gain_ext = {{(SUM_W-8){1'b0}}, w_gain};
    assign w_op_ext   = {{(SUM_W-DIFF_W){w_mul_op[DIFF_W-1]}}, w_mul_op};
    assign w_product  = w_gain_ext * w_op_ext;

    // Integral accumulate with saturation at the 16-bit signed limits.
    assign w_int_ext = {{(SUM_W-INT_W){r_integral[INT_W-1]}}, r_integral};
    assign w_int_sum = w_int_ext + w_product;
    assign w_int_sat = (w_int_sum > c_int_max) ? INT_W'(32767)  :
                       (w_int_sum < c_int_min) ? INT_W'(-32768) :
                       w_int_sum[INT_W-1:0];

    // Final sum uses the integral already updated in MUL_I of this sample.
    assign w_pid_sum = r_p_term + w_int_ext + r_d_term;
    assign w_shifted = w_pid_sum >>> OUT_SHIFT;
    assign w_clamped = w_shifted[SUM_W-1]        ? 8'd0   :
                       (w_shifted > c_ctrl_max)  ? 8'd255 :
                       w_shifted[7:0];

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        w_next_state = r_state;
        sample_req   = 1'b0;
        ctrl_valid   = 1'b0;
        busy         = (r_state != IDLE);
        case (r_state)
            IDLE:    if (w_tick) w_next_state = WAIT_FB;
            WAIT_FB: begin
                sample_req = 1'b1;
                if (fb_valid) w_next_state = MUL_P;
            end
            MUL_P:   w_next_state = MUL_I;
            MUL_I:   w_next_state = MUL_D;
            MUL_D:   w_next_state = SUM;
            SUM:     w_next_state = OUT;
            OUT: begin
                ctrl_valid   = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Datapath registers; clr overrides the integral/prev_error updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_error      <= '0;
            r_prev_error <= '0;
            r_integral   <= '0;
            r_p_term     <= '0;
            r_d_term     <= '0;
            r_control    <= 8'd0;
        end else begin
            if (r_state == WAIT_FB && fb_valid) r_error <= w_err_new;
            if (r_state == MUL_P)               r_p_term <= w_product;
            if (r_state == MUL_D)               r_d_term <= w_product;
            if (r_state == SUM)                 r_control <= w_clamped;
            if (clr) begin
                r_integral   <= '0;
                r_prev_error <= '0;
            end else begin
                if (r_state == MUL_I) r_integral   <= w_int_sat;
                if (r_state == SUM)   r_prev_error <= r_error;
            end
        end
    end

    // Sticky overrun: a tick arriving while a sample is still in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (clr) begin
            r_overrun <= 1'b0;
        end else if (w_tick && r_state != IDLE) begin
            r_overrun <= 1'b1;
        end
    end

    assign control = r_control;
    assign overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_pid_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pid_sequencer
// Description : Directed self-checking bench for pid_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pid_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       clr;
    logic [7:0] sample_div;
    logic [7:0] setpoint;
    logic [7:0] feedback;
    logic       fb_valid;
    logic       sample_req;
    logic [7:0] control;
    logic       ctrl_valid;
    logic       busy;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pid_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .clr        (clr),
        .sample_div (sample_div),
        .setpoint   (setpoint),
        .feedback   (feedback),
        .fb_valid   (fb_valid),
        .sample_req (sample_req),
        .control    (control),
        .ctrl_valid (ctrl_valid),
        .busy       (busy),
        .overrun    (overrun)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (sample_req !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        check(tag, {15'd0, sample_req}, 16'd1);
    endtask

    // One full sample: fb_valid is high in cycle 0, ctrl_valid in cycle 5.
    task automatic run_sample(input string tag, input logic [7:0] sp,
                              input logic [7:0] fb, input logic [7:0] exp_ctrl);
        setpoint = sp;
        feedback = fb;
        wait_req({tag, "_req"});
        fb_valid = 1'b1;
        step();
        fb_valid = 1'b0;
        check({tag, "_busy"}, {15'd0, busy}, 16'd1);
        repeat (3) step();
        check({tag, "_early"}, {15'd0, ctrl_valid}, 16'd0);
        step();
        check({tag, "_valid"}, {15'd0, ctrl_valid}, 16'd1);
        check({tag, "_ctrl"}, {8'd0, control}, {8'd0, exp_ctrl});
        step();
        check({tag, "_pulse"}, {15'd0, ctrl_valid}, 16'd0);
        check({tag, "_hold"}, {8'd0, control}, {8'd0, exp_ctrl});
        check({tag, "_idle"}, {15'd0, busy}, 16'd0);
    endtask

    initial begin
        int pulses;
        rst_n      = 1'b0;
        ena        = 1'b0;
        clr        = 1'b0;
        sample_div = 8'd20;
        setpoint   = 8'd0;
        feedback   = 8'd0;
        fb_valid   = 1'b0;
        repeat (3) step();

        // Reset state
        check("rst_ctrl",  {8'd0, control},     16'd0);
        check("rst_valid", {15'd0, ctrl_valid}, 16'd0);
        check("rst_busy",  {15'd0, busy},       16'd0);
        check("rst_req",   {15'd0, sample_req}, 16'd0);
        check("rst_ovr",   {15'd0, overrun},    16'd0);

        rst_n = 1'b1;
        step();
        ena = 1'b1;

        // 160 + 20 + 10 = 190 >> 4 = 11, then 160 + 40 + 0 = 200 >> 4 = 12
        run_sample("s1", 8'd100, 8'd90, 8'd11);
        run_sample("s2", 8'd100, 8'd90, 8'd12);
        check("s2_ovr", {15'd0, overrun}, 16'd0);

        // Reset while the FSM sits in MUL_I
        wait_req("mid_req");
        fb_valid = 1'b1;
        step();
        fb_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        check("mid_ctrl", {8'd0, control},     16'd0);
        check("mid_busy", {15'd0, busy},       16'd0);
        check("mid_vld",  {15'd0, ctrl_valid}, 16'd0);
        check("mid_req0", {15'd0, sample_req}, 16'd0);
        ena = 1'b0;
        step();
        rst_n = 1'b1;
        pulses = 0;
        repeat (8) begin
            step();
            if (ctrl_valid === 1'b1) pulses++;
        end
        check("mid_nopulse", pulses[15:0], 16'd0);

        // From reset: 4080 + 510 + 255 = 4845 >> 4 = 302 -> 255
        ena = 1'b1;
        run_sample("sat_hi", 8'd255, 8'd0, 8'd255);
        // Error -200 makes the sum negative -> 0
        run_sample("sat_lo", 8'd0, 8'd200, 8'd0);

        // Overrun with a short period and withheld feedback
        rst_n = 1'b0;
        step();
        rst_n      = 1'b1;
        sample_div = 8'd2;
        setpoint   = 8'd50;
        feedback   = 8'd40;
        wait_req("ovr_req");
        repeat (10) step();
        check("ovr_flag", {15'd0, overrun},    16'd1);
        check("ovr_wait", {15'd0, sample_req}, 16'd1);
        fb_valid = 1'b1;
        step();
        fb_valid = 1'b0;
        pulses = 0;
        repeat (10) begin
            if (ctrl_valid === 1'b1) pulses++;
            step();
        end
        check("ovr_pulses", pulses[15:0], 16'd1);
        check("ovr_sticky", {15'd0, overrun}, 16'd1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_ovr", {15'd0, overrun}, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
